// File: rtl/mmio_port_responder.sv
// Memory-mapped port/timer peripheral: an output register, a synchronized input port
// with change detection, and a down-counting timer with optional auto-reload and interrupt.
module mmio_port_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h1001_0400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Hit,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic        Irq
);

   typedef enum logic {IDLE, RUN} timerState_t;

   logic [31:0] outReg, loadReg, countReg, countNext;
   logic [3:0]  ctrlReg;
   logic        chgReg, expReg, chgNext, expNext;
   logic        chgSet, expSet, statusWrite;
   logic [7:0]  syncStage1Reg, syncInReg, prevInReg;
   logic [2:0]  regSel;
   logic        busWrite;
   timerState_t timerState;

   assign Hit      = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00);
   assign regSel   = Address[4:2];
   assign busWrite = Hit && MemWrite;
   assign PortOut  = outReg;
   // Irq is built from registered flags and enables only, so no bus-to-Irq combinational path.
   assign Irq      = (chgReg && ctrlReg[2]) || (expReg && ctrlReg[3]);

   assign timerState = (ctrlReg[0] && (countReg != 32'd0)) ? RUN : IDLE;

   always_comb begin
      countNext = countReg;
      expSet    = 1'b0;
      if (timerState == RUN) begin
         if (countReg == 32'd1) begin
            expSet    = 1'b1;
            countNext = ctrlReg[1] ? loadReg : 32'd0;
         end else begin
            countNext = countReg - 32'd1;
         end
      end
      // A LOAD write overrides both decrement and reload at the same edge.
      if (busWrite && (regSel == 3'd3)) begin
         countNext = WriteData;
      end
      statusWrite = busWrite && (regSel == 3'd2);
      chgSet      = (syncInReg != prevInReg);
      chgNext     = chgSet || (chgReg && !(statusWrite && WriteData[0]));
      expNext     = expSet || (expReg && !(statusWrite && WriteData[1]));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outReg        <= 32'd0;
         loadReg       <= 32'd0;
         countReg      <= 32'd0;
         ctrlReg       <= 4'd0;
         chgReg        <= 1'b0;
         expReg        <= 1'b0;
         syncStage1Reg <= 8'd0;
         syncInReg     <= 8'd0;
         prevInReg     <= 8'd0;
      end else begin
         syncStage1Reg <= PortIn;
         syncInReg     <= syncStage1Reg;
         prevInReg     <= syncInReg;
         countReg      <= countNext;
         chgReg        <= chgNext;
         expReg        <= expNext;
         if (busWrite && (regSel == 3'd0)) outReg  <= WriteData;
         if (busWrite && (regSel == 3'd3)) loadReg <= WriteData;
         if (busWrite && (regSel == 3'd5)) ctrlReg <= WriteData[3:0];
      end
   end

   always_comb begin
      ReadData = 32'd0;
      if (Hit && MemRead) begin
         case (regSel)
            3'd0:    ReadData = outReg;
            3'd1:    ReadData = {24'd0, syncInReg};
            3'd2:    ReadData = {30'd0, expReg, chgReg};
            3'd3:    ReadData = loadReg;
            3'd4:    ReadData = countReg;
            3'd5:    ReadData = {28'd0, ctrlReg};
            default: ReadData = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Scoreboard bench for mmio_port_responder: expected bus reads are queued when driven
// and popped when the combinational response is sampled.
module tb_mmio_port_responder;

   localparam logic [31:0] BASE = 32'h1001_0400;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] Address = 32'd0;
   logic [31:0] WriteData = 32'd0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] ReadData;
   logic        Hit;
   logic [7:0]  PortIn = 8'd0;
   logic [31:0] PortOut;
   logic        Irq;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        hit;
   } expect_t;

   expect_t expQ[$];
   int vectors = 0;
   int miscompares = 0;

   mmio_port_responder #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
      .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
      .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic busWr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
   endtask

   // Read between clock edges; expectation is pushed first, then popped and compared.
   task automatic busRd(input string tag, input logic [31:0] a, input logic [31:0] d, input logic h);
      expect_t e;
      e.tag = tag; e.data = d; e.hit = h;
      expQ.push_back(e);
      Address = a; MemRead = 1'b1; MemWrite = 1'b0;
      #1;
      e = expQ.pop_front();
      checkVal({e.tag, ".data"}, ReadData, e.data);
      checkVal({e.tag, ".hit"}, {31'd0, Hit}, {31'd0, e.hit});
      MemRead = 1'b0;
   endtask

   initial begin
      // Reset state, and bus still decodes combinationally while reset is low.
      #2;
      checkVal("rst.portout", PortOut, 32'd0);
      checkVal("rst.irq", {31'd0, Irq}, 32'd0);
      busRd("rst.out", BASE + 32'h00, 32'd0, 1'b1);
      @(negedge clk);
      reset = 1'b1;

      // OUT register
      busWr(BASE + 32'h00, 32'hDEAD_BEEF);
      checkVal("out.portout", PortOut, 32'hDEAD_BEEF);
      busRd("out.read", BASE + 32'h00, 32'hDEAD_BEEF, 1'b1);

      // Input synchronizer and change flag
      @(negedge clk);
      PortIn = 8'hA5;
      tick(2);
      busRd("in.sync", BASE + 32'h04, 32'h0000_00A5, 1'b1);
      busRd("chg.notyet", BASE + 32'h08, 32'd0, 1'b1);
      tick(1);
      busRd("chg.set", BASE + 32'h08, 32'h1, 1'b1);
      checkVal("chg.irqmasked", {31'd0, Irq}, 32'd0);
      busWr(BASE + 32'h14, 32'h4);
      checkVal("chg.irq", {31'd0, Irq}, 32'd1);
      busWr(BASE + 32'h08, 32'h1);
      busRd("chg.w1c", BASE + 32'h08, 32'd0, 1'b1);
      checkVal("chg.irqclr", {31'd0, Irq}, 32'd0);
      busWr(BASE + 32'h14, 32'h0);

      // One-shot timer
      busWr(BASE + 32'h0C, 32'd3);
      busRd("os.count3", BASE + 32'h10, 32'd3, 1'b1);
      busWr(BASE + 32'h14, 32'h9);
      busRd("os.ctrl", BASE + 32'h14, 32'h9, 1'b1);
      busRd("os.start", BASE + 32'h10, 32'd3, 1'b1);
      tick(1);
      busRd("os.count2", BASE + 32'h10, 32'd2, 1'b1);
      tick(1);
      busRd("os.count1", BASE + 32'h10, 32'd1, 1'b1);
      checkVal("os.irqlow", {31'd0, Irq}, 32'd0);
      tick(1);
      busRd("os.count0", BASE + 32'h10, 32'd0, 1'b1);
      busRd("os.exp", BASE + 32'h08, 32'h2, 1'b1);
      checkVal("os.irq", {31'd0, Irq}, 32'd1);
      tick(2);
      busRd("os.stay0", BASE + 32'h10, 32'd0, 1'b1);
      busRd("os.load", BASE + 32'h0C, 32'd3, 1'b1);
      busWr(BASE + 32'h08, 32'h2);
      busRd("os.w1c", BASE + 32'h08, 32'd0, 1'b1);
      busWr(BASE + 32'h14, 32'h0);

      // Auto-reload timer and set-beats-clear
      busWr(BASE + 32'h0C, 32'd2);
      busWr(BASE + 32'h14, 32'h3);
      busRd("ar.start", BASE + 32'h10, 32'd2, 1'b1);
      tick(1);
      busRd("ar.count1", BASE + 32'h10, 32'd1, 1'b1);
      tick(1);
      busRd("ar.reload", BASE + 32'h10, 32'd2, 1'b1);
      busRd("ar.exp", BASE + 32'h08, 32'h2, 1'b1);
      busWr(BASE + 32'h08, 32'h2);
      busRd("ar.clr", BASE + 32'h08, 32'd0, 1'b1);
      busRd("ar.clrcnt", BASE + 32'h10, 32'd1, 1'b1);
      busWr(BASE + 32'h08, 32'h2);
      busRd("ar.setwins", BASE + 32'h08, 32'h2, 1'b1);
      busRd("ar.cnt2", BASE + 32'h10, 32'd2, 1'b1);
      checkVal("ar.irqmasked", {31'd0, Irq}, 32'd0);
      // Clearing TEN freezes the count; that edge still decrements once.
      busWr(BASE + 32'h14, 32'h2);
      tick(3);
      busRd("ar.frozen", BASE + 32'h10, 32'd1, 1'b1);
      busWr(BASE + 32'h14, 32'h3);
      busRd("ar.resume", BASE + 32'h10, 32'd1, 1'b1);
      tick(1);
      busRd("ar.reload2", BASE + 32'h10, 32'd2, 1'b1);

      // Reset in the middle of counting with CHG pending
      busWr(BASE + 32'h14, 32'h0);
      busWr(BASE + 32'h0C, 32'd5);
      @(negedge clk);
      PortIn = 8'h5A;
      tick(3);
      busWr(BASE + 32'h14, 32'h4);
      busRd("mr.count5", BASE + 32'h10, 32'd5, 1'b1);
      checkVal("mr.irqpre", {31'd0, Irq}, 32'd1);
      #2;
      reset = 1'b0;
      PortIn = 8'h00;
      #1;
      checkVal("mr.irq", {31'd0, Irq}, 32'd0);
      checkVal("mr.portout", PortOut, 32'd0);
      busRd("mr.count", BASE + 32'h10, 32'd0, 1'b1);
      busRd("mr.status", BASE + 32'h08, 32'd0, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      tick(4);
      busRd("mr.after", BASE + 32'h08, 32'd0, 1'b1);
      busRd("mr.load", BASE + 32'h0C, 32'd0, 1'b1);
      busRd("mr.ctrl", BASE + 32'h14, 32'd0, 1'b1);

      // Misaligned, out-of-window, reserved and CTRL upper bits
      busWr(BASE + 32'h02, 32'h1234_5678);
      busRd("mis.read", BASE + 32'h02, 32'd0, 1'b0);
      busWr(BASE + 32'h20, 32'h1234_5678);
      busRd("oow.read", BASE + 32'h20, 32'd0, 1'b0);
      busRd("oow.out", BASE + 32'h00, 32'd0, 1'b1);
      checkVal("oow.portout", PortOut, 32'd0);
      busWr(BASE + 32'h18, 32'hFFFF_FFFF);
      busRd("rsv.read", BASE + 32'h18, 32'd0, 1'b1);
      busWr(BASE + 32'h14, 32'hFFFF_FFF0);
      busRd("ctrl.upper", BASE + 32'h14, 32'd0, 1'b1);
      busWr(BASE + 32'h00, 32'h0000_00FF);
      Address = BASE;
      MemRead = 1'b0;
      #1;
      checkVal("noread.data", ReadData, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
